// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe -- two-stage pipelined carry-select adder/subtractor with a
// valid/ready handshake on both sides.
//
// Stage 1 builds both candidate sums per SEG_W segment, one assuming carry-in 0
// and one assuming carry-in 1. Stage 2 picks one candidate per segment through
// a mux chain that starts at the effective carry-in.
//
// Parameters
//   WIDTH     operand/sum width, must be a multiple of SEG_W
//   SEG_W     carry-select segment width
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  operand beat present          in_ready  beat accepted this cycle
//   a, b      operands                      cin       carry in (ignored when sub=1)
//   sub       0: a+b+cin, 1: a-b
//   out_valid result beat present           out_ready downstream accepts result
//   sum       result mod 2^WIDTH            cout      carry out (sub: 1 = no borrow)
//   ovf       two's-complement overflow
module csel_adder_pipe #(
   parameter int WIDTH = 32,
   parameter int SEG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG = WIDTH / SEG_W;

   generate
      if ((WIDTH % SEG_W) != 0 || NSEG < 1) begin : g_bad_params
         $error("csel_adder_pipe: WIDTH must be a non-zero multiple of SEG_W");
      end
   endgenerate

   // handshake
   logic v1, v2;
   logic adv1, adv2, accept;

   assign adv2      = !v2 | out_ready;
   assign adv1      = !v1 | adv2;
   assign in_ready  = adv1 & !rst;
   assign accept    = in_valid & in_ready;
   assign out_valid = v2;

   // stage 1: per-segment ripple for both carry-in assumptions
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] s0_d, s1_d;
   logic [NSEG-1:0]  co0_d, co1_d;
   logic             g, p, c0r, c1r;

   always_comb begin
      b_eff = sub ? ~b : b;
      s0_d  = '0;
      s1_d  = '0;
      co0_d = '0;
      co1_d = '0;
      g     = 1'b0;
      p     = 1'b0;
      c0r   = 1'b0;
      c1r   = 1'b1;
      for (int k = 0; k < NSEG; k++) begin
         c0r = 1'b0;
         c1r = 1'b1;
         for (int i = 0; i < SEG_W; i++) begin
            g = a[k*SEG_W+i] & b_eff[k*SEG_W+i];
            p = a[k*SEG_W+i] ^ b_eff[k*SEG_W+i];
            s0_d[k*SEG_W+i] = p ^ c0r;
            s1_d[k*SEG_W+i] = p ^ c1r;
            c0r = g | (p & c0r);
            c1r = g | (p & c1r);
         end
         co0_d[k] = c0r;
         co1_d[k] = c1r;
      end
   end

   logic [WIDTH-1:0] s0_q, s1_q;
   logic [NSEG-1:0]  co0_q, co1_q;
   logic             c0_q, amsb_q, bmsb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1     <= 1'b0;
         s0_q   <= '0;
         s1_q   <= '0;
         co0_q  <= '0;
         co1_q  <= '0;
         c0_q   <= 1'b0;
         amsb_q <= 1'b0;
         bmsb_q <= 1'b0;
      end else if (adv1) begin
         v1     <= accept;
         s0_q   <= s0_d;
         s1_q   <= s1_d;
         co0_q  <= co0_d;
         co1_q  <= co1_d;
         c0_q   <= sub ? 1'b1 : cin;
         amsb_q <= a[WIDTH-1];
         bmsb_q <= b_eff[WIDTH-1];
      end
   end

   // stage 2: select chain, one 2:1 mux per segment
   logic [WIDTH-1:0] sum_d;
   logic             carry, ovf_d;

   always_comb begin
      sum_d = '0;
      carry = c0_q;
      for (int k = 0; k < NSEG; k++) begin
         sum_d[k*SEG_W +: SEG_W] = carry ? s1_q[k*SEG_W +: SEG_W] : s0_q[k*SEG_W +: SEG_W];
         carry = carry ? co1_q[k] : co0_q[k];
      end
      ovf_d = (amsb_q == bmsb_q) & (sum_d[WIDTH-1] != amsb_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2   <= 1'b0;
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else if (adv2) begin
         v2   <= v1;
         sum  <= sum_d;
         cout <= carry;
         ovf  <= ovf_d;
      end
   end

endmodule

// File: tb/tb_csel_adder_pipe.sv
module tb_csel_adder_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;

   csel_adder_pipe #(.WIDTH(32), .SEG_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        o;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        c;
      logic        o;
   } vec_t;

   res_t q[$];
   int   occ = 0;
   int   npop = 0;
   logic prev_stall = 1'b0;
   logic [31:0] prev_sum = '0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Reference from plain integer arithmetic, overflow from true signed range.
   function automatic res_t ref_f(input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input logic s);
      res_t r;
      logic [32:0] u;
      longint sx, sy, tv;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (s) begin
         u   = {1'b0, x} - {1'b0, y};
         r.c = (x >= y);
         tv  = sx - sy;
      end else begin
         u   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
         r.c = u[32];
         tv  = sx + sy + longint'(ci);
      end
      r.s = u[31:0];
      r.o = (tv > 64'sd2147483647) || (tv < -64'sd2147483648);
      return r;
   endfunction

   // One clock cycle of streaming with scoreboard, occupancy model and stall checks.
   task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic is, input logic ordy, output logic acc);
      logic pop;
      res_t e;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = is;
      out_ready = ordy;
      #1;
      chk1("in_ready_vs_occupancy", in_ready, (occ < 2) || ordy);
      if (prev_stall) begin
         chk1("stall_valid_held", out_valid, 1'b1);
         chk32("stall_sum_stable", sum, prev_sum);
      end
      acc = iv && in_ready;
      pop = out_valid && ordy;
      if (pop) begin
         if (q.size() == 0) begin
            chk1("unexpected_result", 1'b1, 1'b0);
         end else begin
            e = q.pop_front();
            chk32("stream_sum", sum, e.s);
            chk1("stream_cout", cout, e.c);
            chk1("stream_ovf", ovf, e.o);
         end
         npop++;
      end
      if (acc) q.push_back(ref_f(ia, ib, ic, is));
      occ = occ + (acc ? 1 : 0) - (pop ? 1 : 0);
      prev_stall = out_valid && !ordy;
      prev_sum   = sum;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'hFFFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'h7FFF_FFFF;
         3: return 32'h0000_00FF << (8 * $urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[12];
      logic acc;
      int   next_a;
      int   cyc;

      vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1]  = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
      vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[5]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
      vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[7]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      vecs[8]  = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
      vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[11] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

      // reset with in_valid asserted
      in_valid = 1'b1;
      a = 32'h1234_5678;
      b = 32'h1;
      repeat (3) @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b0);
      chk32("rst_sum", sum, 32'h0);
      chk1("rst_cout", cout, 1'b0);
      chk1("rst_ovf", ovf, 1'b0);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk1("post_rst_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("post_rst_no_result", out_valid, 1'b0);
      end

      // directed vectors with exact latency check
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         a = vecs[i].a;
         b = vecs[i].b;
         cin = vecs[i].cin;
         sub = vecs[i].sub;
         in_valid = 1'b1;
         out_ready = 1'b1;
         #1;
         chk1("vec_in_ready", in_ready, 1'b1);
         @(negedge clk);
         in_valid = 1'b0;
         chk1("vec_not_early", out_valid, 1'b0);
         @(negedge clk);
         chk1("vec_out_valid", out_valid, 1'b1);
         chk32($sformatf("vec%0d_sum", i), sum, vecs[i].s);
         chk1($sformatf("vec%0d_cout", i), cout, vecs[i].c);
         chk1($sformatf("vec%0d_ovf", i), ovf, vecs[i].o);
      end
      @(negedge clk);
      chk1("vec_drained", out_valid, 1'b0);

      // backpressure: a=1..6, b=0x10, out_ready low for cycles 2..5
      occ = 0;
      npop = 0;
      prev_stall = 1'b0;
      next_a = 1;
      cyc = 0;
      while (npop < 6 && cyc < 40) begin
         cycle(next_a <= 6, 32'(next_a), 32'h10, 1'b0, 1'b0, !(cyc >= 2 && cyc <= 5), acc);
         if (cyc == 2) chk1("bp_full_in_ready_low", in_ready, 1'b0);
         if (cyc == 6) begin
            chk1("bp_pop_push_in_ready", in_ready, 1'b1);
            chk1("bp_pop_push_accept", acc, 1'b1);
            chk32("bp_first_out", sum, 32'h11);
         end
         if (acc) next_a++;
         cyc++;
      end
      chk32("bp_pops", 32'(npop), 32'd6);
      chk32("bp_occupancy_after_pop_push", 32'(occ), 32'd0);

      // random stream with random handshakes
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, acc);
      end
      for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      chk32("random_drained", 32'(q.size()), 32'd0);

      // reset mid-operation discards in-flight beats
      cycle(1'b1, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0, acc);
      @(negedge clk);
      chk1("midrst_full_before", out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("midrst_out_valid_async", out_valid, 1'b0);
      chk1("midrst_in_ready", in_ready, 1'b0);
      chk32("midrst_sum", sum, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      q.delete();
      occ = 0;
      prev_stall = 1'b0;
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      @(negedge clk);
      chk1("midrst_no_stale", out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
